// File: rtl/lsl16_iter_pkg.sv
// Shared definitions for the iterative 16-bit logical shift-left unit:
// widths, FSM states and the carry/overflow flag helper used by both datapaths.
package lsl_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned SHW   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic carry;
    logic ovf;
  } lsl_flags_t;

  // Flags for shifting value left by amount: carry is the last bit pushed out,
  // ovf is set when the top amount+1 bits of value are not all equal.
  function automatic lsl_flags_t lsl_flags(input logic [WIDTH-1:0] value,
                                           input logic [SHW-1:0]   amount);
    lsl_flags_t f;
    f = '0;
    for (int unsigned k = 1; k < WIDTH; k++) begin
      if (WIDTH - k == 32'(amount))
        f.carry = value[k];
      if (k - 1 >= WIDTH - 1 - 32'(amount))
        f.ovf = f.ovf | (value[k] ^ value[k-1]);
    end
    return f;
  endfunction

endpackage

// File: rtl/lsl16_iter_if.sv
// Request/result bundle between the ALU sequencer and the shift-left unit.
interface lsl16_iter_if;
  import lsl_pkg::*;

  logic             start;
  logic [WIDTH-1:0] inp;
  logic [SHW-1:0]   shift_value;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             carry;
  logic             ovf;

  modport master (
    output start, inp, shift_value,
    input  ready, busy, done, out, carry, ovf
  );

  modport slave (
    input  start, inp, shift_value,
    output ready, busy, done, out, carry, ovf
  );

endinterface

// File: rtl/lsl_barrel16.sv
// Single-cycle log-stage left shifter with carry/overflow, used when LSL_FAST_EN is defined.
module lsl_barrel16
  import lsl_pkg::*;
(
  input  logic [WIDTH-1:0] value,
  input  logic [SHW-1:0]   amount,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf
);

  logic [WIDTH-1:0] stage [SHW+1];
  lsl_flags_t       flags;

  assign stage[0] = value;

  for (genvar s = 0; s < SHW; s++) begin : g_stage
    assign stage[s+1] = amount[s] ? (stage[s] << (2 ** s)) : stage[s];
  end

  assign flags  = lsl_flags(value, amount);
  assign result = stage[SHW];
  assign carry  = flags.carry;
  assign ovf    = flags.ovf;

endmodule

// File: rtl/lsl16_iter.sv
// Iterative 16-bit logical shift-left, one bit per clock, with carry and sticky
// signed-overflow flags. Define LSL_FAST_EN for a single-cycle barrel datapath.
module lsl16_iter
  import lsl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  lsl16_iter_if.slave  bus
);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic             carry_q;
  logic             ovf_q;
  logic             done_q;
  logic             busy_q;
  logic             ready_q;
  logic             accept_c;

`ifdef LSL_FAST_EN
  logic [WIDTH-1:0] fast_res;
  logic             fast_carry;
  logic             fast_ovf;

  lsl_barrel16 u_barrel (
    .value  (bus.inp),
    .amount (bus.shift_value),
    .result (fast_res),
    .carry  (fast_carry),
    .ovf    (fast_ovf)
  );
`else
  logic [SHW-1:0] cnt;
  lsl_flags_t     step;

  assign step = lsl_flags(acc, SHW'(1));
`endif

  assign accept_c = bus.start & ready_q;

  // Control FSM and datapath; ready/busy/done are registered with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      acc     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
`ifndef LSL_FAST_EN
      cnt     <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (accept_c) begin
`ifdef LSL_FAST_EN
        acc     <= fast_res;
        carry_q <= fast_carry;
        ovf_q   <= fast_ovf;
        state   <= DONE;
        done_q  <= 1'b1;
        busy_q  <= 1'b0;
        ready_q <= 1'b1;
`else
        acc     <= bus.inp;
        cnt     <= bus.shift_value;
        carry_q <= 1'b0;
        ovf_q   <= 1'b0;
        if (bus.shift_value != '0) begin
          state   <= SHIFT;
          busy_q  <= 1'b1;
          ready_q <= 1'b0;
        end else begin
          state   <= DONE;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
`endif
      end else begin
        case (state)
`ifndef LSL_FAST_EN
          SHIFT: begin
            carry_q <= step.carry;
            ovf_q   <= ovf_q | step.ovf;
            acc     <= {acc[WIDTH-2:0], 1'b0};
            cnt     <= cnt - SHW'(1);
            if (cnt == SHW'(1)) begin
              state   <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
            end
          end
`endif
          default: begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.out   = acc;
  assign bus.carry = carry_q;
  assign bus.ovf   = ovf_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.ready = ready_q;

endmodule

// File: tb/tb_lsl16_iter.sv
// Randomized self-checking bench for lsl16_iter against an arithmetic reference
// model; latency and busy expectations follow LSL_FAST_EN.
module tb_lsl16_iter;

`ifdef LSL_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  lsl16_iter_if bus ();

  lsl16_iter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic on a wide word and signed integers.
  task automatic ref_op(input logic [15:0] a, input int n,
                        output logic [15:0] res, output logic c, output logic o);
    logic [31:0] wide;
    int          sa;
    int          sr;
    wide = {16'h0000, a} << n;
    res  = wide[15:0];
    c    = wide[16];
    sa   = int'($signed(a));
    sr   = int'($signed(res));
    o    = (sa * (1 << n)) != sr;
  endtask

  // Present a request now and let the next rising edge accept it.
  task automatic accept_now(input logic [15:0] a, input logic [3:0] n);
    bus.start       = 1'b1;
    bus.inp         = a;
    bus.shift_value = n;
    @(posedge clk);
    #1;
    bus.start       = 1'b0;
    bus.inp         = 16'($urandom);
    bus.shift_value = 4'($urandom);
  endtask

  // Wait for done after an accept, then check latency, busy time and results.
  task automatic finish_op(input string tag, input logic [15:0] a, input logic [3:0] n,
                           input bit inject);
    int          edges;
    int          busy_cyc;
    logic [15:0] er;
    logic        ec;
    logic        eo;
    ref_op(a, int'(n), er, ec, eo);
    edges    = 0;
    busy_cyc = bus.busy ? 1 : 0;
    while (!bus.done && edges < 40) begin
      if (inject && edges == 1) begin
        bus.start       = 1'b1;
        bus.inp         = 16'hAAAA;
        bus.shift_value = 4'd3;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      edges++;
      if (bus.busy) busy_cyc++;
    end
    check({tag, "_latency"}, 32'(edges), FAST ? 32'd0 : 32'(n));
    check({tag, "_busy_cycles"}, 32'(busy_cyc), FAST ? 32'd0 : 32'(n));
    check({tag, "_out"}, 32'(bus.out), 32'(er));
    check({tag, "_carry"}, 32'(bus.carry), 32'(ec));
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
    check({tag, "_ready"}, 32'(bus.ready), 32'd1);
  endtask

  logic [15:0] ra;
  logic [3:0]  rn;
  int          gap;

  initial begin
    rst             = 1'b0;
    bus.start       = 1'b0;
    bus.inp         = '0;
    bus.shift_value = '0;
    repeat (2) @(negedge clk);
    check("rst_out", 32'(bus.out), 32'd0);
    check("rst_carry", 32'(bus.carry), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd1);
    rst = 1'b1;
    @(negedge clk);

    @(negedge clk); accept_now(16'h000B, 4'd1);  finish_op("b_n1", 16'h000B, 4'd1, 1'b0);
    @(negedge clk); accept_now(16'h4001, 4'd2);  finish_op("ovf_n2", 16'h4001, 4'd2, 1'b0);
    @(negedge clk); accept_now(16'hFFFF, 4'd15); finish_op("ones_n15", 16'hFFFF, 4'd15, 1'b0);
    @(negedge clk); accept_now(16'h1234, 4'd0);  finish_op("zero_shift", 16'h1234, 4'd0, 1'b0);

    // Start while busy must be dropped; then a back-to-back accept from DONE.
    @(negedge clk); accept_now(16'h0C31, 4'd6);  finish_op("ignore", 16'h0C31, 4'd6, 1'b1);
    accept_now(16'h0003, 4'd3);                  finish_op("b2b", 16'h0003, 4'd3, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("hold_out", 32'(bus.out), 32'h0018);
    check("hold_done", 32'(bus.done), 32'd0);

    // Asynchronous reset mid-shift abandons the operation.
    @(negedge clk); accept_now(16'h00FF, 4'd8);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_out", 32'(bus.out), 32'd0);
    check("midrst_carry", 32'(bus.carry), 32'd0);
    check("midrst_ovf", 32'(bus.ovf), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_ready", 32'(bus.ready), 32'd1);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); accept_now(16'h0001, 4'd4);  finish_op("post_rst", 16'h0001, 4'd4, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra  = 16'($urandom);
      rn  = 4'($urandom_range(0, 15));
      gap = int'($urandom_range(0, 2));
      if (gap > 0) repeat (gap) @(negedge clk);
      accept_now(ra, rn);
      finish_op("rand", ra, rn, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
